// File: rtl/pipe_if_id.sv
// IF/ID pipeline register: holds the fetched PC/instruction for decode, with hazard stall and flush.
// Optional build macro PIPE_IF_ID_VALID_EN adds VALID_OUT, a flag that tells a real slot from a bubble.
module pipe_if_id #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [WIDTH-1:0] INSTRUCTION_IN,
    output logic [WIDTH-1:0] PC_OUT,
`ifdef PIPE_IF_ID_VALID_EN
    output logic [WIDTH-1:0] INSTRUCTION_OUT,
    output logic             VALID_OUT
`else
    output logic [WIDTH-1:0] INSTRUCTION_OUT
`endif
);

    // Reset is tested first so X on FLUSH/STALL during reset cannot reach the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_OUT          <= FLUSH_VALUE;
            INSTRUCTION_OUT <= FLUSH_VALUE;
        end else if (FLUSH) begin
            PC_OUT          <= FLUSH_VALUE;
            INSTRUCTION_OUT <= FLUSH_VALUE;
        end else if (!STALL) begin
            PC_OUT          <= PC_IN;
            INSTRUCTION_OUT <= INSTRUCTION_IN;
        end
    end

`ifdef PIPE_IF_ID_VALID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            VALID_OUT <= 1'b0;
        end else if (FLUSH) begin
            VALID_OUT <= 1'b0;
        end else if (!STALL) begin
            VALID_OUT <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_id.sv
// Directed bench for pipe_if_id: reset, load, stall, flush, flush-over-stall, async reset mid-run.
module tb_pipe_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        FLUSH;
    logic        STALL;
    logic [31:0] PC_IN;
    logic [31:0] INSTRUCTION_IN;
    logic [31:0] PC_OUT;
    logic [31:0] INSTRUCTION_OUT;
`ifdef PIPE_IF_ID_VALID_EN
    logic        VALID_OUT;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_if_id #(.WIDTH(32), .FLUSH_VALUE(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .FLUSH           (FLUSH),
        .STALL           (STALL),
        .PC_IN           (PC_IN),
        .INSTRUCTION_IN  (INSTRUCTION_IN),
        .PC_OUT          (PC_OUT),
`ifdef PIPE_IF_ID_VALID_EN
        .INSTRUCTION_OUT (INSTRUCTION_OUT),
        .VALID_OUT       (VALID_OUT)
`else
        .INSTRUCTION_OUT (INSTRUCTION_OUT)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic vld);
        check({tag, "_pc"}, PC_OUT, pc);
        check({tag, "_ins"}, INSTRUCTION_OUT, ins);
`ifdef PIPE_IF_ID_VALID_EN
        check({tag, "_vld"}, {31'b0, VALID_OUT}, {31'b0, vld});
`else
        if (vld === 1'bx) $display("unused");
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        FLUSH          = 1'b0;
        STALL          = 1'b0;
        PC_IN          = 32'hDEADBEEF;
        INSTRUCTION_IN = 32'h0BADC0DE;
        tick();
        check_out("preload", 32'hDEADBEEF, 32'h0BADC0DE, 1'b1);

        // Reset between edges must clear at once.
        #3;
        rst            = 1'b0;
        PC_IN          = 32'h12345678;
        FLUSH          = 1'bx;
        STALL          = 1'bx;
        #1;
        check_out("rst_async", 32'h0, 32'h0, 1'b0);
        tick();
        check_out("rst_edge1", 32'h0, 32'h0, 1'b0);
        tick();
        check_out("rst_edge2", 32'h0, 32'h0, 1'b0);

        rst            = 1'b1;
        FLUSH          = 1'b0;
        STALL          = 1'b0;
        INSTRUCTION_IN = 32'hAAAAAAAA;
        tick();
        check_out("load", 32'h12345678, 32'hAAAAAAAA, 1'b1);

        STALL          = 1'b1;
        PC_IN          = 32'h87654321;
        INSTRUCTION_IN = 32'hBBBBBBBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall", 32'h12345678, 32'hAAAAAAAA, 1'b1);
        end
        STALL = 1'b0;
        tick();
        check_out("unstall", 32'h87654321, 32'hBBBBBBBB, 1'b1);

        FLUSH = 1'b1;
        tick();
        check_out("flush", 32'h0, 32'h0, 1'b0);
        FLUSH          = 1'b0;
        PC_IN          = 32'hFFFFFFFF;
        INSTRUCTION_IN = 32'h11111111;
        tick();
        check_out("post_flush", 32'hFFFFFFFF, 32'h11111111, 1'b1);

        FLUSH = 1'b1;
        STALL = 1'b1;
        tick();
        check_out("flush_over_stall", 32'h0, 32'h0, 1'b0);
        FLUSH = 1'b0;
        STALL = 1'b0;
        tick();
        check_out("reload", 32'hFFFFFFFF, 32'h11111111, 1'b1);

        STALL = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_out("rst_mid_stall", 32'h0, 32'h0, 1'b0);
        PC_IN          = 32'h0BADF00D;
        INSTRUCTION_IN = 32'hCAFEBABE;
        STALL          = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_release_hold", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_release_load", 32'h0BADF00D, 32'hCAFEBABE, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
